// File: rtl/exec_pkg.sv
// Shared encodings for the execute stage: micro-ops, condition codes,
// FSM states and NZCV bit positions.
package exec_pkg;

    typedef enum logic [4:0] {
        UOP_ADD    = 5'd0,
        UOP_SUB    = 5'd1,
        UOP_AND    = 5'd2,
        UOP_OR     = 5'd3,
        UOP_XOR    = 5'd4,
        UOP_MOV    = 5'd5,
        UOP_CMP    = 5'd6,
        UOP_LSL    = 5'd7,
        UOP_LSR    = 5'd8,
        UOP_LOAD   = 5'd10,
        UOP_STORE  = 5'd11,
        UOP_BRANCH = 5'd12
    } uop_e;

    typedef enum logic [3:0] {
        COND_EQ = 4'd0,  COND_NE = 4'd1,  COND_CS = 4'd2,  COND_CC = 4'd3,
        COND_MI = 4'd4,  COND_PL = 4'd5,  COND_VS = 4'd6,  COND_VC = 4'd7,
        COND_HI = 4'd8,  COND_LS = 4'd9,  COND_GE = 4'd10, COND_LT = 4'd11,
        COND_GT = 4'd12, COND_LE = 4'd13, COND_AL = 4'd14, COND_NV = 4'd15
    } cond_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MEM   = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/exec_alu_flags.sv
// Combinational ALU, NZCV generation and branch-condition evaluation.
// LOAD/STORE reuse the adder to form the effective address.
module exec_alu_flags
    import exec_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int UOP_W  = 5
) (
    input  logic [UOP_W-1:0]  uop,
    input  logic [DATA_W-1:0] lhs,
    input  logic [DATA_W-1:0] rhs,
    input  logic [3:0]        flags_in,
    input  logic [3:0]        cond,
    output logic [DATA_W-1:0] result,
    output logic [3:0]        flags_nxt,
    output logic              rd_we,
    output logic              taken
);

    localparam int SH_W = $clog2(DATA_W);
    localparam int MSB  = DATA_W - 1;

    logic [DATA_W:0] sum_ext;
    logic [DATA_W:0] dif_ext;
    logic            v_add;
    logic            v_sub;
    logic            set_nz;
    logic            c_new;
    logic            v_new;
    logic            fn, fz, fc, fv;

    // Carry out of the subtract path is the "no borrow" indication.
    assign sum_ext = {1'b0, lhs} + {1'b0, rhs};
    assign dif_ext = {1'b0, lhs} + {1'b0, ~rhs} + {{DATA_W{1'b0}}, 1'b1};
    assign v_add   = (lhs[MSB] == rhs[MSB]) & (sum_ext[MSB] != lhs[MSB]);
    assign v_sub   = (lhs[MSB] != rhs[MSB]) & (dif_ext[MSB] != lhs[MSB]);

    // Result, write enable and C/V selection per micro-op; unknown uops do nothing.
    always_comb begin
        result = '0;
        rd_we  = 1'b0;
        set_nz = 1'b0;
        c_new  = flags_in[FLAG_C];
        v_new  = flags_in[FLAG_V];
        case (uop)
            UOP_W'(UOP_ADD): begin
                result = sum_ext[MSB:0];
                rd_we  = 1'b1;
                set_nz = 1'b1;
                c_new  = sum_ext[DATA_W];
                v_new  = v_add;
            end
            UOP_W'(UOP_SUB), UOP_W'(UOP_CMP): begin
                result = dif_ext[MSB:0];
                rd_we  = (uop == UOP_W'(UOP_SUB));
                set_nz = 1'b1;
                c_new  = dif_ext[DATA_W];
                v_new  = v_sub;
            end
            UOP_W'(UOP_AND): begin result = lhs & rhs; rd_we = 1'b1; set_nz = 1'b1; end
            UOP_W'(UOP_OR):  begin result = lhs | rhs; rd_we = 1'b1; set_nz = 1'b1; end
            UOP_W'(UOP_XOR): begin result = lhs ^ rhs; rd_we = 1'b1; set_nz = 1'b1; end
            UOP_W'(UOP_MOV): begin result = rhs;       rd_we = 1'b1; set_nz = 1'b1; end
            UOP_W'(UOP_LSL): begin result = lhs << rhs[SH_W-1:0]; rd_we = 1'b1; set_nz = 1'b1; end
            UOP_W'(UOP_LSR): begin result = lhs >> rhs[SH_W-1:0]; rd_we = 1'b1; set_nz = 1'b1; end
            UOP_W'(UOP_LOAD), UOP_W'(UOP_STORE): result = sum_ext[MSB:0];
            default: ;
        endcase
    end

    assign flags_nxt = set_nz ? {result[MSB], (result == '0), c_new, v_new} : flags_in;

    assign fn = flags_in[FLAG_N];
    assign fz = flags_in[FLAG_Z];
    assign fc = flags_in[FLAG_C];
    assign fv = flags_in[FLAG_V];

    // Condition evaluation against the currently committed flags.
    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_EQ: taken = fz;
            COND_NE: taken = ~fz;
            COND_CS: taken = fc;
            COND_CC: taken = ~fc;
            COND_MI: taken = fn;
            COND_PL: taken = ~fn;
            COND_VS: taken = fv;
            COND_VC: taken = ~fv;
            COND_HI: taken = fc & ~fz;
            COND_LS: taken = ~fc | fz;
            COND_GE: taken = (fn == fv);
            COND_LT: taken = (fn != fv);
            COND_GT: taken = ~fz & (fn == fv);
            COND_LE: taken = fz | (fn != fv);
            COND_AL: taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/exec_stage_pipe.sv
// Execute stage: register file, NZCV flags, issue FSM and req/ack data-memory port.
// Optional macro EXEC_MEM_TIMEOUT_EN adds a memory timeout and sticky mem_err output.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  ST_IDLE  | ready for an instruction; ALU ops complete on the accept edge
//  ST_MEM   | load/store outstanding, mem_req held until ack (or timeout)
//  ST_FLUSH | one cycle after a taken branch: redirect + retire, no accept
module exec_stage_pipe
    import exec_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NREGS  = 16,
    parameter int UOP_W  = 5
`ifdef EXEC_MEM_TIMEOUT_EN
    , parameter int MEM_TIMEOUT = 64
`endif
    , localparam int SEL_W = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [UOP_W-1:0]  in_uop,
    input  logic              in_num_to_rhs,
    input  logic [DATA_W-1:0] in_num,
    input  logic [SEL_W-1:0]  in_sel_p0,
    input  logic [SEL_W-1:0]  in_sel_p1,
    input  logic [SEL_W-1:0]  in_sel_in,
    input  logic [3:0]        in_cond,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              redirect_valid,
    output logic [DATA_W-1:0] redirect_delta,
    output logic              retire_valid,
    output logic [3:0]        flags_out
`ifdef EXEC_MEM_TIMEOUT_EN
    , output logic            mem_err
`endif
);

    state_e            state, state_nxt;
    logic [DATA_W-1:0] regs [NREGS];
    logic [3:0]        flags;
    logic [DATA_W-1:0] rd_p0, rd_p1, rhs;
    logic [DATA_W-1:0] alu_result;
    logic [3:0]        alu_flags;
    logic              alu_we, cond_taken;
    logic              is_ld, is_st, is_br, is_mem, accept;
    logic              ack_hit, timeout;
    logic [SEL_W-1:0]  dst_q;
    logic [DATA_W-1:0] delta_q;
    logic              retire_q;

    assign rd_p0  = regs[in_sel_p0];
    assign rd_p1  = regs[in_sel_p1];
    assign rhs    = in_num_to_rhs ? in_num : rd_p0;

    assign is_ld  = (in_uop == UOP_W'(UOP_LOAD));
    assign is_st  = (in_uop == UOP_W'(UOP_STORE));
    assign is_br  = (in_uop == UOP_W'(UOP_BRANCH));
    assign is_mem = is_ld | is_st;
    assign accept = in_valid & (state == ST_IDLE);

    exec_alu_flags #(.DATA_W(DATA_W), .UOP_W(UOP_W)) u_alu (
        .uop       (in_uop),
        .lhs       (rd_p1),
        .rhs       (rhs),
        .flags_in  (flags),
        .cond      (in_cond),
        .result    (alu_result),
        .flags_nxt (alu_flags),
        .rd_we     (alu_we),
        .taken     (cond_taken)
    );

    // An ack is only meaningful while a request is actually outstanding.
    assign ack_hit = (state == ST_MEM) & mem_ack;

`ifdef EXEC_MEM_TIMEOUT_EN
    localparam int TMR_W = $clog2(MEM_TIMEOUT + 1);
    logic [TMR_W-1:0] tmr;

    // Ack in the terminal cycle takes priority over the abort.
    assign timeout = (state == ST_MEM) & ~mem_ack & (tmr == '0);

    // Down-counter loaded on entry to MEM; terminal count flags the abort; sticky error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmr     <= '0;
            mem_err <= 1'b0;
        end else begin
            if (accept & is_mem)
                tmr <= TMR_W'(MEM_TIMEOUT - 1);
            else if ((state == ST_MEM) && (tmr != '0))
                tmr <= tmr - 1'b1;
            if (timeout)
                mem_err <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (is_mem)                   state_nxt = ST_MEM;
                    else if (is_br && cond_taken) state_nxt = ST_FLUSH;
                end
            end
            ST_MEM:   if (ack_hit || timeout) state_nxt = ST_IDLE;
            ST_FLUSH: state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Register file and flags: ALU write-back on accept, load write-back on ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            flags <= '0;
        end else begin
            if (accept) begin
                if (alu_we) regs[in_sel_in] <= alu_result;
                flags <= alu_flags;
            end
            if (ack_hit && !mem_we)
                regs[dst_q] <= mem_rdata;
        end
    end

    // Memory-port latches, branch delta and the retire pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            dst_q     <= '0;
            delta_q   <= '0;
            retire_q  <= 1'b0;
        end else begin
            if (accept && is_mem) begin
                mem_we    <= is_st;
                mem_addr  <= alu_result;
                mem_wdata <= rd_p0;
                dst_q     <= in_sel_in;
            end
            if (accept && is_br)
                delta_q <= in_num;
            retire_q <= (accept & ~is_mem & ~(is_br & cond_taken)) | ack_hit | timeout;
        end
    end

    assign in_ready       = (state == ST_IDLE);
    assign mem_req        = (state == ST_MEM);
    assign redirect_valid = (state == ST_FLUSH);
    assign redirect_delta = (state == ST_FLUSH) ? delta_q : '0;
    assign retire_valid   = retire_q | (state == ST_FLUSH);
    assign flags_out      = flags;

endmodule
